// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared width default, register index type and ABI register numbers
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd1;
  localparam reg_addr_t REG_SP   = 5'd2;
  localparam reg_addr_t REG_T0   = 5'd5;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback bundle of the register file with busy scoreboard
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32
);

  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            reg_write;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] result;

  modport master (
    output rs1, rs2, issue_valid, issue_rd, reg_write, rd, result,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy
  );

  modport slave (
    input  rs1, rs2, issue_valid, issue_rd, reg_write, rd, result,
    output rs1_val, rs2_val, rs1_busy, rs2_busy
  );

endinterface

// File: rtl/regfile_sb_bits.sv
// rtl/regfile_sb_bits.sv - per-register busy vector with set/clear priority and two lookups
module regfile_sb_bits #(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_valid,
  input  logic [$clog2(NREGS)-1:0] set_idx,
  input  logic                     clr_valid,
  input  logic [$clog2(NREGS)-1:0] clr_idx,
  input  logic [$clog2(NREGS)-1:0] lk1_idx,
  output logic                     lk1_busy,
  input  logic [$clog2(NREGS)-1:0] lk2_idx,
  output logic                     lk2_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Set is applied after clear so a same-cycle reissue keeps the new producer pending.
  always_comb begin
    busy_nxt = busy;
    if (clr_valid && (int'(clr_idx) < NREGS)) begin
      busy_nxt[clr_idx] = 1'b0;
    end
    if (set_valid && (set_idx != '0) && (int'(set_idx) < NREGS)) begin
      busy_nxt[set_idx] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign lk1_busy = (int'(lk1_idx) < NREGS) ? busy[lk1_idx] : 1'b0;
  assign lk2_busy = (int'(lk2_idx) < NREGS) ? busy[lk2_idx] : 1'b0;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - NREGS x XLEN register file, 2R/1W, with busy scoreboard
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] SP_RESET = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] rs2_reg;
  logic            rs1_sb;
  logic            rs2_sb;

  assign wr_en = bus.reg_write && (bus.rd != '0) && (int'(bus.rd) < NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
    end else if (wr_en) begin
      regs[bus.rd] <= bus.result;
    end
  end

  // x0 and out-of-range indices read as zero regardless of array contents.
  assign rs1_reg = ((bus.rs1 != '0) && (int'(bus.rs1) < NREGS)) ? regs[bus.rs1] : '0;
  assign rs2_reg = ((bus.rs2 != '0) && (int'(bus.rs2) < NREGS)) ? regs[bus.rs2] : '0;

  regfile_sb_bits #(
    .NREGS (NREGS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (bus.issue_valid),
    .set_idx   (bus.issue_rd),
    .clr_valid (bus.reg_write),
    .clr_idx   (bus.rd),
    .lk1_idx   (bus.rs1),
    .lk1_busy  (rs1_sb),
    .lk2_idx   (bus.rs2),
    .lk2_busy  (rs2_sb)
  );

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = wr_en && (bus.rd == bus.rs1);
  assign byp2 = wr_en && (bus.rd == bus.rs2);

  // A same-cycle reissue of the bypassed register still has a pending producer.
  assign bus.rs1_val  = byp1 ? bus.result : rs1_reg;
  assign bus.rs2_val  = byp2 ? bus.result : rs2_reg;
  assign bus.rs1_busy = (byp1 && !(bus.issue_valid && (bus.issue_rd == bus.rs1))) ? 1'b0 : rs1_sb;
  assign bus.rs2_busy = (byp2 && !(bus.issue_valid && (bus.issue_rd == bus.rs2))) ? 1'b0 : rs2_sb;
`else
  assign bus.rs1_val  = rs1_reg;
  assign bus.rs2_val  = rs2_reg;
  assign bus.rs1_busy = rs1_sb;
  assign bus.rs2_busy = rs2_sb;
`endif

endmodule
